// File: rtl/led_pattern_gen.sv
// led_pattern_gen: four-mode LED pattern generator with debounced keys and speed/direction switches
// Ports: fpga_clk_50 clock; fpga_rst synchronous active-high reset; usr_key_i[2:0] low-active keys
// (0 next mode, 1 pause/resume, 2 brightness step); usr_sw_i[1:0] speed, usr_sw_i[2] direction;
// usr_led_o LED drive; mode_o current mode; tick_o one-cycle pulse per pattern step.
// Define LED_PWM_DIM_EN to build the key2 brightness PWM; without it key2 is ignored.
module led_pattern_gen #(
  parameter int N_LED = 8,
  parameter int STEP_CYC = 50_000_000,
  parameter int DB_CYC = 1_000_000
) (
  input  logic             fpga_clk_50,
  input  logic             fpga_rst,
  input  logic [2:0]       usr_key_i,
  input  logic [2:0]       usr_sw_i,
  output logic [N_LED-1:0] usr_led_o,
  output logic [1:0]       mode_o,
  output logic             tick_o
);
  localparam int CW = $clog2(STEP_CYC);
  localparam int DW = $clog2(DB_CYC + 1);
  typedef enum logic [1:0] {ALT, RUN, BOUNCE, COUNT} mode_t;
  function automatic logic [N_LED-1:0] alt_init();
    logic [N_LED-1:0] v;
    for (int i = 0; i < N_LED; i++) v[i] = (i % 2 == 0);
    return v;
  endfunction
  localparam logic [N_LED-1:0] ALT_INIT = alt_init();
  localparam logic [N_LED-1:0] ONE_HOT0 = {{(N_LED-1){1'b0}}, 1'b1};
  logic [2:0] key_s1, key_s2, sw_s1, sw_s2, key_evt;
  logic [N_LED-1:0] led_gate, pat, pat_nx, pat_init, bnc;
  logic [CW-1:0] step_cnt;
  logic [31:0] period_m1;
  logic paused, dir, dir_nx, tick;
  mode_t mode, mode_nx;
  always_ff @(posedge fpga_clk_50) begin
    if (fpga_rst) begin
      key_s1 <= 3'b111;
      key_s2 <= 3'b111;
      sw_s1 <= 3'b000;
      sw_s2 <= 3'b000;
    end else begin
      key_s1 <= usr_key_i;
      key_s2 <= key_s1;
      sw_s1 <= usr_sw_i;
      sw_s2 <= sw_s1;
    end
  end
  for (genvar k = 0; k < 3; k++) begin : g_db
    logic [DW-1:0] db_cnt;
    logic dn, evt, hit;
    assign hit = ~key_s2[k] & ~dn & (db_cnt == DW'(DB_CYC - 1));
    always_ff @(posedge fpga_clk_50) begin
      if (fpga_rst) begin
        db_cnt <= '0;
        dn <= 1'b0;
        evt <= 1'b0;
      end else begin
        evt <= hit;
        dn <= ~key_s2[k] & (dn | hit);
        db_cnt <= (key_s2[k] | dn | hit) ? '0 : db_cnt + 1'b1;
      end
    end
    assign key_evt[k] = evt;
  end
  assign period_m1 = 32'(STEP_CYC >> sw_s2[1:0]) - 32'd1;
  assign tick = ~paused & (32'(step_cnt) >= period_m1);
  assign mode_nx = mode_t'(mode + 2'd1);
  assign pat_init = mode_nx == ALT ? ALT_INIT : mode_nx == COUNT ? '0 : ONE_HOT0;
  assign bnc = dir ? pat >> 1 : pat << 1;
  assign pat_nx = mode == ALT    ? ~pat :
                  mode == RUN    ? (sw_s2[2] ? {pat[0], pat[N_LED-1:1]} : {pat[N_LED-2:0], pat[N_LED-1]}) :
                  mode == BOUNCE ? bnc :
                                   (sw_s2[2] ? pat - 1'b1 : pat + 1'b1);
  assign dir_nx = mode != BOUNCE ? dir : bnc[N_LED-1] ? 1'b1 : bnc[0] ? 1'b0 : dir;
  always_ff @(posedge fpga_clk_50) begin
    if (fpga_rst) begin
      mode <= ALT;
      pat <= ALT_INIT;
      step_cnt <= '0;
      paused <= 1'b0;
      dir <= 1'b0;
      tick_o <= 1'b0;
      mode_o <= 2'd0;
      usr_led_o <= '0;
    end else begin
      paused <= paused ^ key_evt[1];
      tick_o <= tick & ~key_evt[0];
      mode_o <= mode;
      usr_led_o <= pat & led_gate;
      if (key_evt[0]) begin
        mode <= mode_nx;
        pat <= pat_init;
        step_cnt <= '0;
        dir <= 1'b0;
      end else if (tick) begin
        pat <= pat_nx;
        dir <= dir_nx;
        step_cnt <= '0;
      end else if (!paused) begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end
`ifdef LED_PWM_DIM_EN
  logic [2:0] bright, pwm_cnt;
  always_ff @(posedge fpga_clk_50) begin
    if (fpga_rst) begin
      bright <= 3'd7;
      pwm_cnt <= 3'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (key_evt[2]) bright <= bright + 1'b1;
    end
  end
  assign led_gate = {N_LED{pwm_cnt <= bright}};
`else
  logic unused_key2;
  assign unused_key2 = key_evt[2];
  assign led_gate = '1;
`endif
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed table-driven self-checking bench for led_pattern_gen
module tb_led_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] usr_key_i = 3'b111;
  logic [2:0] usr_sw_i = 3'b000;
  logic [7:0] usr_led_o;
  logic [1:0] mode_o;
  logic tick_o;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [2:0] sw;
    logic [7:0] led;
    logic [1:0] mode;
  } vec_t;
  vec_t vt[$];
  always #10 clk = ~clk;
  led_pattern_gen #(.N_LED(8), .STEP_CYC(16), .DB_CYC(4)) dut (
    .fpga_clk_50(clk),
    .fpga_rst(rst),
    .usr_key_i(usr_key_i),
    .usr_sw_i(usr_sw_i),
    .usr_led_o(usr_led_o),
    .mode_o(mode_o),
    .tick_o(tick_o)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic cycles_to_tick(output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (tick_o) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic run_vecs(input int lo, input int hi);
    int n;
    for (int i = lo; i <= hi; i++) begin
      usr_sw_i = vt[i].sw;
      cycles_to_tick(n);
      check($sformatf("vec%0d_tick_seen", i), 32'(n > 0), 1);
      @(negedge clk);
      check($sformatf("vec%0d_led", i), usr_led_o, vt[i].led);
      check($sformatf("vec%0d_mode", i), mode_o, vt[i].mode);
    end
  endtask
  task automatic key0_adv(input int hold, input logic [1:0] em, input logic [7:0] el);
    bit seen;
    int i;
    seen = 0;
    i = 0;
    usr_key_i[0] = 1'b0;
    while (i < hold + 20 && !(seen && i >= hold)) begin
      i++;
      @(negedge clk);
      if (i == hold) usr_key_i[0] = 1'b1;
      if (!seen && mode_o == em) begin
        seen = 1;
        check($sformatf("key0_to_mode%0d_led", em), usr_led_o, el);
      end
    end
    usr_key_i[0] = 1'b1;
    check($sformatf("key0_to_mode%0d_seen", em), 32'(seen), 1);
  endtask
  task automatic press(input int k);
    usr_key_i[k] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 4) usr_key_i[k] = 1'b1;
    end
  endtask
  task automatic count_on(output int c);
    c = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (usr_led_o != 8'h00) c++;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n;
    vt.push_back('{3'b000, 8'hAA, 2'd0});
    vt.push_back('{3'b000, 8'h55, 2'd0});
    vt.push_back('{3'b000, 8'h02, 2'd1});
    vt.push_back('{3'b000, 8'h04, 2'd1});
    vt.push_back('{3'b000, 8'h08, 2'd1});
    vt.push_back('{3'b000, 8'h10, 2'd1});
    vt.push_back('{3'b000, 8'h20, 2'd1});
    vt.push_back('{3'b000, 8'h40, 2'd1});
    vt.push_back('{3'b000, 8'h80, 2'd1});
    vt.push_back('{3'b000, 8'h01, 2'd1});
    vt.push_back('{3'b100, 8'h80, 2'd1});
    vt.push_back('{3'b100, 8'h40, 2'd1});
    vt.push_back('{3'b000, 8'h80, 2'd1});
    vt.push_back('{3'b011, 8'h02, 2'd2});
    vt.push_back('{3'b011, 8'h04, 2'd2});
    vt.push_back('{3'b011, 8'h08, 2'd2});
    vt.push_back('{3'b011, 8'h10, 2'd2});
    vt.push_back('{3'b011, 8'h20, 2'd2});
    vt.push_back('{3'b011, 8'h40, 2'd2});
    vt.push_back('{3'b011, 8'h80, 2'd2});
    vt.push_back('{3'b111, 8'h40, 2'd2});
    vt.push_back('{3'b111, 8'h20, 2'd2});
    vt.push_back('{3'b111, 8'h10, 2'd2});
    vt.push_back('{3'b011, 8'h08, 2'd2});
    vt.push_back('{3'b011, 8'h04, 2'd2});
    vt.push_back('{3'b011, 8'h02, 2'd2});
    vt.push_back('{3'b011, 8'h01, 2'd2});
    vt.push_back('{3'b011, 8'h02, 2'd2});
    vt.push_back('{3'b100, 8'hFF, 2'd3});
    vt.push_back('{3'b100, 8'hFE, 2'd3});
    repeat (3) @(negedge clk);
    check("rst_led", usr_led_o, 8'h00);
    check("rst_mode", mode_o, 2'd0);
    check("rst_tick", tick_o, 1'b0);
    rst = 1'b0;
    cycles_to_tick(n);
    check("first_tick_latency", n, 16);
    @(negedge clk);
    check("alt_first_led", usr_led_o, 8'hAA);
    cycles_to_tick(n);
    check("alt_period", n, 15);
    @(negedge clk);
    check("alt_second_led", usr_led_o, 8'h55);
    run_vecs(0, 1);
    key0_adv(4, 2'd1, 8'h01);
    run_vecs(2, 12);
    usr_sw_i = 3'b011;
    key0_adv(4, 2'd2, 8'h01);
    run_vecs(13, 27);
    usr_sw_i = 3'b100;
    key0_adv(4, 2'd3, 8'h00);
    run_vecs(28, 29);
    usr_key_i[1] = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 4) usr_key_i[1] = 1'b1;
      if (tick_o) n++;
    end
    check("pause_ticks", n, 0);
    check("pause_led", usr_led_o, 8'hFE);
    usr_key_i[1] = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 4) usr_key_i[1] = 1'b1;
      if (tick_o) begin
        n = i;
        break;
      end
    end
    usr_key_i[1] = 1'b1;
    check("resume_latency", n, 15);
    @(negedge clk);
    check("resume_led", usr_led_o, 8'hFD);
    key0_adv(100, 2'd0, 8'h55);
    repeat (12) @(negedge clk);
    check("hold_no_repeat", mode_o, 2'd0);
    usr_sw_i = 3'b000;
    cycles_to_tick(n);
    repeat (8) @(negedge clk);
    usr_sw_i = 3'b011;
    cycles_to_tick(n);
    check("speed_change_tick", n, 3);
    usr_sw_i = 3'b000;
    usr_key_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    usr_key_i[0] = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_event", mode_o, 2'd0);
    key0_adv(4, 2'd1, 8'h01);
    usr_key_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_led", usr_led_o, 8'h00);
    check("midrst_mode", mode_o, 2'd0);
    check("midrst_tick", tick_o, 1'b0);
    usr_key_i[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_mode", mode_o, 2'd0);
    check("post_rst_led", usr_led_o, 8'h55);
    repeat (20) @(negedge clk);
    check("post_rst_no_event", mode_o, 2'd0);
`ifdef LED_PWM_DIM_EN
    press(2);
    count_on(n);
    check("pwm_b0_on_cycles", n, 2);
    press(2);
    count_on(n);
    check("pwm_b1_on_cycles", n, 4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    count_on(n);
    check("pwm_rst_on_cycles", n, 16);
`else
    press(2);
    count_on(n);
    check("key2_ignored_on_cycles", n, 16);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
